// File: rtl/dice_bank_if.sv
// Bundle between the debounced push-button side and the display/score side of dice_bank.
// The bank drives the dice, the total and the status flags; the button side only drives the roll request.
interface dice_bank_if #(
  parameter int FACES    = 6,
  parameter int NUM_DICE = 2
);
  localparam int W  = $clog2(FACES + 1);
  localparam int SW = $clog2(NUM_DICE * FACES + 1);

  logic                  button;
  logic [NUM_DICE*W-1:0] throw;
  logic [SW-1:0]         total;
  logic                  rolling;
  logic                  valid;

  modport master (output button, input throw, total, rolling, valid);
  modport slave  (input button, output throw, total, rolling, valid);
endinterface

// File: rtl/dice_bank.sv
// Multi-die electronic dice: the dice spin as an odometer while the button is held,
// then freeze, settle for SETTLE_CYCLES clocks and present a registered, valid result.
module dice_bank #(
  parameter int FACES         = 6,
  parameter int NUM_DICE      = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  dice_bank_if.slave  bus
);
  localparam int W  = $clog2(FACES + 1);
  localparam int SW = $clog2(NUM_DICE * FACES + 1);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ROLL, SETTLE, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   dice_q [NUM_DICE];
  logic [W-1:0]   dice_d [NUM_DICE];
  logic [SW-1:0]  total_q, total_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rolling_q, rolling_d;
  logic           valid_q, valid_d;
  logic           advance;
  logic           carry;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.button) state_d = ROLL;
      end
      ROLL: begin
        if (bus.button) begin
          advance = 1'b1;
        end else begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (bus.button) begin
          state_d = ROLL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.button) state_d = ROLL;
      end
      default: state_d = IDLE;
    endcase

    // Odometer step: die 0 always advances, a wrap from FACES back to 1 carries upward.
    carry = advance;
    for (int i = 0; i < NUM_DICE; i++) begin
      dice_d[i] = dice_q[i];
      if (carry) begin
        if (dice_q[i] == W'(FACES)) begin
          dice_d[i] = W'(1);
        end else begin
          dice_d[i] = dice_q[i] + W'(1);
          carry     = 1'b0;
        end
      end
    end

    total_d = '0;
    for (int i = 0; i < NUM_DICE; i++) begin
      total_d = total_d + SW'(dice_d[i]);
    end

    rolling_d = (state_d == ROLL);
    valid_d   = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      for (int i = 0; i < NUM_DICE; i++) dice_q[i] <= W'(1);
      total_q   <= SW'(NUM_DICE);
      cnt_q     <= '0;
      rolling_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      for (int i = 0; i < NUM_DICE; i++) dice_q[i] <= dice_d[i];
      total_q   <= total_d;
      cnt_q     <= cnt_d;
      rolling_q <= rolling_d;
      valid_q   <= valid_d;
    end
  end

  for (genvar g = 0; g < NUM_DICE; g++) begin : g_pack
    assign bus.throw[g*W +: W] = dice_q[g];
  end

  assign bus.total   = total_q;
  assign bus.rolling = rolling_q;
  assign bus.valid   = valid_q;
endmodule

// File: tb/tb_dice_bank.sv
// Self-checking bench for dice_bank: a default bank (6 faces, 2 dice, settle 4) and a wide
// bank (8 faces, 3 dice, settle 1), each compared every cycle against an odometer-index model.
module tb_dice_bank;
  localparam int P_IDLE   = 0;
  localparam int P_ROLL   = 1;
  localparam int P_SETTLE = 2;
  localparam int P_DONE   = 3;

  typedef struct {
    int count;
    int phase;
    int since_release;
  } model_t;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   num_checks;
  int   num_errors;
  model_t ma;
  model_t mb;

  dice_bank_if #(.FACES(6), .NUM_DICE(2)) bus_a ();
  dice_bank_if #(.FACES(8), .NUM_DICE(3)) bus_b ();

  dice_bank #(.FACES(6), .NUM_DICE(2), .SETTLE_CYCLES(4)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  dice_bank #(.FACES(8), .NUM_DICE(3), .SETTLE_CYCLES(1)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The model keeps the bank as a single odometer index 0..FACES^NUM_DICE-1.
  function automatic model_t model_step(model_t m, bit r, bit b, int period, int settle);
    model_t n = m;
    if (r) begin
      n.count = 0;
      n.phase = P_IDLE;
      n.since_release = 0;
    end else begin
      case (m.phase)
        P_IDLE: if (b) n.phase = P_ROLL;
        P_ROLL: begin
          if (b) begin
            n.count = (m.count + 1) % period;
          end else begin
            n.phase = P_SETTLE;
            n.since_release = 0;
          end
        end
        P_SETTLE: begin
          if (b) begin
            n.phase = P_ROLL;
          end else begin
            n.since_release = m.since_release + 1;
            if (n.since_release == settle) n.phase = P_DONE;
          end
        end
        default: if (b) n.phase = P_ROLL;
      endcase
    end
    return n;
  endfunction

  function automatic logic [63:0] expect_throw(int count, int faces, int nd, int w);
    logic [63:0] v = '0;
    int c = count;
    for (int i = 0; i < nd; i++) begin
      v = v | (64'(c % faces + 1) << (i * w));
      c = c / faces;
    end
    return v;
  endfunction

  function automatic int expect_total(int count, int faces, int nd);
    int s = 0;
    int c = count;
    for (int i = 0; i < nd; i++) begin
      s = s + (c % faces) + 1;
      c = c / faces;
    end
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkModel();
    checkOutput("a_throw",   64'(bus_a.throw),   expect_throw(ma.count, 6, 2, 3));
    checkOutput("a_total",   64'(bus_a.total),   64'(expect_total(ma.count, 6, 2)));
    checkOutput("a_rolling", 64'(bus_a.rolling), 64'(ma.phase == P_ROLL));
    checkOutput("a_valid",   64'(bus_a.valid),   64'(ma.phase == P_DONE));
    checkOutput("b_throw",   64'(bus_b.throw),   expect_throw(mb.count, 8, 3, 4));
    checkOutput("b_total",   64'(bus_b.total),   64'(expect_total(mb.count, 8, 3)));
    checkOutput("b_rolling", 64'(bus_b.rolling), 64'(mb.phase == P_ROLL));
    checkOutput("b_valid",   64'(bus_b.valid),   64'(mb.phase == P_DONE));
  endtask

  // Inputs change 2 time units after an edge and outputs are compared at the same point.
  task automatic applyStimulus(input bit ra, input bit ba, input bit rb, input bit bb);
    rst_a        = ra;
    bus_a.button = ba;
    rst_b        = rb;
    bus_b.button = bb;
    @(posedge clk);
    ma = model_step(ma, ra, ba, 36, 4);
    mb = model_step(mb, rb, bb, 512, 1);
    #2;
    checkModel();
  endtask

  initial begin
    logic [5:0] t;
    bit         level_a;
    bit         level_b;
    int         run_a;
    int         run_b;

    num_checks   = 0;
    num_errors   = 0;
    ma           = '{0, P_IDLE, 0};
    mb           = '{0, P_IDLE, 0};
    rst_a        = 1'b1;
    rst_b        = 1'b1;
    bus_a.button = 1'b0;
    bus_b.button = 1'b0;
    #1;

    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 0, 1, 0);
    checkOutput("rst_throw",   64'(bus_a.throw),   64'(6'b001_001));
    checkOutput("rst_total",   64'(bus_a.total),   64'd2);
    checkOutput("rst_rolling", 64'(bus_a.rolling), 64'd0);
    checkOutput("rst_valid",   64'(bus_a.valid),   64'd0);
    checkOutput("rst_b_total", 64'(bus_b.total),   64'd3);

    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0);
    checkOutput("press_throw",   64'(bus_a.throw),   64'(6'b010_010));
    checkOutput("press_total",   64'(bus_a.total),   64'd4);
    checkOutput("press_rolling", 64'(bus_a.rolling), 64'd1);

    applyStimulus(0, 0, 0, 0);
    checkOutput("release_rolling", 64'(bus_a.rolling), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) applyStimulus(0, 0, 0, 0);
      if (i < 4) checkOutput("settle_valid_low", 64'(bus_a.valid), 64'd0);
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("done_valid",  64'(bus_a.valid), 64'd1);
    checkOutput("done_throw",  64'(bus_a.throw), 64'(6'b010_010));

    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < 37; k++) begin
      applyStimulus(0, 1, 0, 0);
      t = bus_a.throw;
      for (int i = 0; i < 2; i++) begin
        checkOutput("die_range", 64'(t[i*3 +: 3] >= 3'd1 && t[i*3 +: 3] <= 3'd6), 64'd1);
      end
    end
    checkOutput("wrap_throw", 64'(bus_a.throw), 64'(6'b001_001));
    checkOutput("wrap_total", 64'(bus_a.total), 64'd2);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("repress_valid_low", 64'(bus_a.valid), 64'd0);
    end
    applyStimulus(0, 1, 0, 0);
    checkOutput("repress_rolling", 64'(bus_a.rolling), 64'd1);
    checkOutput("repress_frozen",  64'(bus_a.throw),   64'(6'b001_001));
    applyStimulus(0, 1, 0, 0);
    checkOutput("repress_resume",  64'(bus_a.throw),   64'(6'b001_010));

    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("rst_roll_throw",   64'(bus_a.throw),   64'(6'b001_001));
    checkOutput("rst_roll_total",   64'(bus_a.total),   64'd2);
    checkOutput("rst_roll_rolling", 64'(bus_a.rolling), 64'd0);
    applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("pre_rst_done_valid", 64'(bus_a.valid), 64'd1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("rst_done_valid", 64'(bus_a.valid), 64'd0);
    checkOutput("rst_done_throw", 64'(bus_a.throw), 64'(6'b001_001));

    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1);
    checkOutput("b_die0_eight", 64'(bus_b.throw[3:0]), 64'(4'b1000));
    for (int i = 0; i < 504; i++) applyStimulus(0, 0, 0, 1);
    checkOutput("b_all_eight", 64'(bus_b.throw), 64'(12'h888));
    checkOutput("b_total_24",  64'(bus_b.total), 64'd24);
    applyStimulus(0, 0, 0, 0);
    checkOutput("b_release_valid_low", 64'(bus_b.valid), 64'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("b_valid_after_1", 64'(bus_b.valid), 64'd1);

    level_a = 1'b0;
    level_b = 1'b0;
    run_a   = 0;
    run_b   = 0;
    for (int k = 0; k < 3000; k++) begin
      if (run_a == 0) begin
        level_a = ~level_a;
        run_a   = $urandom_range(1, 12);
      end
      if (run_b == 0) begin
        level_b = ~level_b;
        run_b   = $urandom_range(1, 6);
      end
      run_a--;
      run_b--;
      applyStimulus(($urandom_range(0, 99) == 0), level_a,
                    ($urandom_range(0, 99) == 0), level_b);
    end

    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end
endmodule
